// File: rtl/ppt_pkg.sv
// Shared widths, state encoding and fallback configuration for the PPT pulse path.
package ppt_pkg;

    localparam int unsigned CLK_DIV_W = 5;
    localparam int unsigned TIME_W    = 14;
    localparam int unsigned COUNT_W   = 8;
    localparam int unsigned PrescW    = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } ppt_state_e;

    // Fallback config, also used as the register map reset values.
    localparam logic [CLK_DIV_W-1:0] DefClkDiv = 5'd9;
    localparam logic [TIME_W-1:0]    DefPeriod = 14'd128;
    localparam logic [TIME_W-1:0]    DefWidth  = 14'd1;
    localparam logic [COUNT_W-1:0]   DefCount  = 8'd16;

endpackage

// File: rtl/ppt_tick_gen.sv
// Prescaler producing a one-clk timebase tick every 2^(clk_div+1) enabled clks.
module ppt_tick_gen #(
    parameter int unsigned CLK_DIV_W = ppt_pkg::CLK_DIV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CLK_DIV_W-1:0] clk_div,
    output logic                 tick
);
    import ppt_pkg::*;

    logic [PrescW-1:0] presc_q;
    logic [PrescW-1:0] mask;

    // Low clk_div+1 bits of the prescaler take part in the all-ones compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PrescW; i++) begin
            mask[i] = (unsigned'(i) <= 32'(clk_div));
        end
    end

    assign tick = enable && ((presc_q & mask) == mask);

    // Free-running count while enabled; cleared on run start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (clear) begin
            presc_q <= '0;
        end else if (enable) begin
            presc_q <= presc_q + PrescW'(1);
        end
    end

endmodule

// File: rtl/ppt_pulse_controller.sv
// Thruster fire pulse sequencer: `count` firings, `width` ticks high, every `period` ticks.
module ppt_pulse_controller #(
    parameter int unsigned CLK_DIV_W = ppt_pkg::CLK_DIV_W,
    parameter int unsigned TIME_W    = ppt_pkg::TIME_W,
    parameter int unsigned COUNT_W   = ppt_pkg::COUNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CLK_DIV_W-1:0] clk_div,
    input  logic [TIME_W-1:0]    period,
    input  logic [TIME_W-1:0]    width,
    input  logic [COUNT_W-1:0]   count,
    input  logic                 run,
    output logic                 fire,
    output logic [COUNT_W-1:0]   count_done,
    output logic                 done,
    output logic                 busy
);
    import ppt_pkg::*;

    ppt_state_e           state_q;
    logic [CLK_DIV_W-1:0] clk_div_q;
    logic [TIME_W-1:0]    period_q;
    logic [TIME_W-1:0]    width_q;
    logic [TIME_W-1:0]    phase_q;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_done_q;
    logic                 fire_q;
    logic                 done_q;
    logic                 busy_q;

    logic                 start;
    logic                 active;
    logic                 tick;
    logic                 cfg_bad;
    logic                 last_phase;
    logic [TIME_W-1:0]    w_eff;

    assign start      = (state_q == StIdle) && run;
    assign active     = (state_q == StActive);
    assign cfg_bad    = (period == '0) || (count == '0);
    // Clamp so fire always drops for at least one tick per period.
    assign w_eff      = (width_q < period_q) ? width_q : period_q - TIME_W'(1);
    assign last_phase = (phase_q == period_q - TIME_W'(1));

    ppt_tick_gen #(
        .CLK_DIV_W(CLK_DIV_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (active),
        .clk_div(clk_div_q),
        .tick   (tick)
    );

    // Run FSM with registered outputs; run=0 takes priority over a tick (abort wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            clk_div_q    <= CLK_DIV_W'(DefClkDiv);
            period_q     <= TIME_W'(DefPeriod);
            width_q      <= TIME_W'(DefWidth);
            count_q      <= COUNT_W'(DefCount);
            phase_q      <= '0;
            count_done_q <= '0;
            fire_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    fire_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (run) begin
                        clk_div_q    <= clk_div;
                        period_q     <= period;
                        width_q      <= width;
                        count_q      <= count;
                        phase_q      <= '0;
                        count_done_q <= '0;
                        if (cfg_bad) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StActive;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            fire_q  <= (width != '0) && (period > TIME_W'(1));
                        end
                    end
                end
                StActive: begin
                    if (!run) begin
                        state_q <= StIdle;
                        fire_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (tick) begin
                        if (last_phase) begin
                            phase_q      <= '0;
                            count_done_q <= count_done_q + COUNT_W'(1);
                            if (count_done_q + COUNT_W'(1) == count_q) begin
                                state_q <= StDone;
                                fire_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                fire_q <= (w_eff != '0);
                            end
                        end else begin
                            phase_q <= phase_q + TIME_W'(1);
                            fire_q  <= (phase_q + TIME_W'(1)) < w_eff;
                        end
                    end
                end
                StDone: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign fire       = fire_q;
    assign count_done = count_done_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ppt_pulse_controller.sv
// Randomized bench for ppt_pulse_controller against a closed-form timing model.
module tb_ppt_pulse_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  clk_div;
    logic [13:0] period;
    logic [13:0] width;
    logic [7:0]  count;
    logic        run;
    logic        fire;
    logic [7:0]  count_done;
    logic        done;
    logic        busy;

    always #5 clk = ~clk;

    ppt_pulse_controller dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .period    (period),
        .width     (width),
        .count     (count),
        .run       (run),
        .fire      (fire),
        .count_done(count_done),
        .done      (done),
        .busy      (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam int MIdle   = 0;
    localparam int MActive = 1;
    localparam int MDone   = 2;

    // Model: run position is the number of clks since the start edge (m_k).
    int          m_mode = MIdle;
    int unsigned m_k    = 0;
    int unsigned m_cd   = 0;
    bit          m_done = 1'b0;
    int unsigned s_t, s_p, s_w, s_c;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        case (m_mode)
            MIdle: begin
                if (run) begin
                    s_t  = 32'd1 << (int'(clk_div) + 1);
                    s_p  = int'(period);
                    s_w  = int'(width);
                    s_c  = int'(count);
                    m_cd = 0;
                    if (s_p == 0 || s_c == 0) begin
                        m_mode = MDone;
                        m_done = 1'b1;
                    end else begin
                        m_mode = MActive;
                        m_k    = 1;
                        m_done = 1'b0;
                    end
                end
            end
            MActive: begin
                if (!run) begin
                    m_cd   = ((m_k - 1) / s_t) / s_p;
                    m_done = 1'b0;
                    m_mode = MIdle;
                end else begin
                    m_k++;
                    if ((m_k - 1) / s_t >= s_p * s_c) begin
                        m_mode = MDone;
                        m_done = 1'b1;
                        m_cd   = s_c;
                    end
                end
            end
            default: begin
                if (!run) m_mode = MIdle;
            end
        endcase
    endtask

    task automatic check_outputs();
        int unsigned n, weff;
        bit          e_fire, e_busy, e_done;
        int unsigned e_cd;
        if (m_mode == MActive) begin
            n      = (m_k - 1) / s_t;
            weff   = (s_w < s_p) ? s_w : s_p - 1;
            e_fire = (n % s_p) < weff;
            e_busy = 1'b1;
            e_done = 1'b0;
            e_cd   = n / s_p;
        end else begin
            e_fire = 1'b0;
            e_busy = 1'b0;
            e_done = m_done;
            e_cd   = m_cd;
        end
        check_eq("fire", fire, e_fire);
        check_eq("busy", busy, e_busy);
        check_eq("done", done, e_done);
        check_eq("count_done", count_done, e_cd);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // One start/run/release sequence; hold is the number of edges run stays high.
    task automatic run_trial(input int unsigned cd, input int unsigned p, input int unsigned w,
                             input int unsigned c, input int hold_req, input bit mutate);
        int unsigned total, hold;
        clk_div = 5'(cd);
        period  = 14'(p);
        width   = 14'(w);
        count   = 8'(c);
        run     = 1'b1;
        total   = (p == 0 || c == 0) ? 1 : (32'd1 << (cd + 1)) * p * c + 1;
        if (hold_req > 0) hold = hold_req;
        else if (hold_req < 0 && total > 1) hold = $urandom_range(total - 1, 1);
        else hold = total + $urandom_range(3, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            if (mutate && $urandom_range(5, 0) == 0) begin
                clk_div = 5'($urandom_range(2, 0));
                period  = 14'($urandom_range(9, 0));
                width   = 14'($urandom_range(9, 0));
                count   = 8'($urandom_range(6, 0));
            end
        end
        run = 1'b0;
        for (int i = 0; i < 2 + int'($urandom_range(1, 0)); i++) step();
    endtask

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        clk_div = '0;
        period  = '0;
        width   = '0;
        count   = '0;
        #12;
        check_eq("rst_fire", fire, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_count_done", count_done, 0);
        rst = 1'b0;
        step();

        // Directed cases from the plan, then randomized runs.
        run_trial(0, 4, 1, 3, 0, 1'b0);
        run_trial(0, 4, 1, 3, 9, 1'b0);   // abort on the second pulse
        run_trial(0, 4, 1, 3, 0, 1'b0);   // restart clears count_done
        run_trial(0, 4, 7, 2, 0, 1'b0);   // width clamped
        run_trial(0, 0, 3, 3, 0, 1'b0);
        run_trial(1, 4, 1, 0, 0, 1'b0);
        run_trial(0, 4, 1, 3, 0, 1'b1);   // config changes mid-run are ignored
        run_trial(0, 1, 1, 2, 0, 1'b0);
        run_trial(0, 3, 0, 2, 0, 1'b0);
        for (int t = 0; t < 30; t++) begin
            run_trial($urandom_range(2, 0), $urandom_range(6, 0), $urandom_range(9, 0),
                      $urandom_range(4, 0), ($urandom_range(2, 0) == 0) ? -1 : 0,
                      1'(($urandom_range(3, 0) == 0)));
        end

        // Asynchronous reset while fire is high.
        clk_div = 5'd0;
        period  = 14'd4;
        width   = 14'd2;
        count   = 8'd3;
        run     = 1'b1;
        step();
        step();
        check_eq("pre_rst_fire", fire, 1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_fire", fire, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_done", done, 0);
        check_eq("async_rst_count_done", count_done, 0);
        m_mode = MIdle;
        m_cd   = 0;
        m_done = 1'b0;
        run    = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        run_trial(0, 2, 1, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ppt_pulse_controller.md
Name: ppt_pulse_controller

Overview:
PPT-side consumer of the register map's configuration outputs (clk_div, period, width, count, run). It generates the thruster fire pulse train and returns count_done and done to the register map. A prescaler derives a timebase tick from the system clock. A period/width/count sequencer then fires `count` pulses, each `width` ticks wide, once per `period` ticks.

Parameters:
CLK_DIV_W, 5, width of prescaler select.
TIME_W, 14, width of period/width/phase counters.
COUNT_W, 8, width of firing count and count_done.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
clk_div  input  CLK_DIV_W  prescaler select; tick period = 2^(clk_div+1) clk cycles.
period  input  TIME_W  pulse period in ticks.
width  input  TIME_W  pulse high time in ticks.
count  input  COUNT_W  number of firings per run.
run  input  1  level enable from the register map.
fire  output  1  registered thruster fire pulse.
count_done  output  COUNT_W  firings completed in current/last run.
done  output  1  high when the run completed all firings.
busy  output  1  high in ACTIVE state.

Behaviour:
- Reset (async, rst=1): state IDLE; fire=0, count_done=0, done=0, busy=0; prescaler and phase counter cleared.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE: when run=1 is sampled at edge N:
  - snapshot clk_div, period, width, count into internal registers;
  - clear count_done, done, phase and prescaler;
  - enter ACTIVE at N+1 (busy=1 from N+1).
- Invalid config at start (period==0 or count==0): go to DONE instead of ACTIVE. done=1 at N+1, count_done=0, fire never asserts.
- Snapshots are held for the whole run. Input changes during ACTIVE/DONE are ignored.
- Prescaler (32-bit):
  - increments every clk in ACTIVE;
  - tick is a 1-clk strobe when presc[clk_div:0] are all ones;
  - first tick occurs 2^(clk_div+1) clks after entering ACTIVE.
- Effective width: w_eff = min(width, period-1). Consequences:
  - fire always drops for at least one tick per period;
  - period==1 gives no pulse, but firings are still counted;
  - width==0 gives no pulse, but firings are still counted.
- fire (registered) = (state==ACTIVE) && (phase < w_eff). fire rises at N+1 when w_eff>0.
- On each tick in ACTIVE:
  - if phase == period-1: phase<=0 and count_done<=count_done+1; if count_done+1 == count, go to DONE (fire=0, busy=0, done=1 in the same cycle).
  - else phase<=phase+1.
- DONE: outputs held (done=1, count_done=count). When run=0 is sampled, go to IDLE. done and count_done stay held until the next start.
- Abort: run=0 sampled in ACTIVE gives IDLE next clk with fire=0, busy=0, done=0. count_done keeps the completed-firing value.
- Simultaneous run=0 and final period-end tick: abort wins; count_done is not incremented and done stays 0.
- count_done never exceeds the count snapshot. There is no wrap-around.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). No pulse resumes after rst deasserts unless run=1 is sampled again in IDLE.

Decomposition:
- Shared package ppt_pkg holds:
  - width constants CLK_DIV_W, TIME_W, COUNT_W;
  - state encoding IDLE/ACTIVE/DONE;
  - fallback default config constants (clk_div 9, period 128, width 1, count 16), shared with the register map reset values.
- One sub-module, ppt_tick_gen:
  - inputs clk, rst, clear, enable, clk_div;
  - output tick;
  - contains the 32-bit prescaler and all-ones compare.

Test Plan:
- clk_div=0, period=4, width=1, count=3, run held 1 → fire high 2 clks of every 8; count_done steps 1,2,3; done=1 and busy=0 exactly 1+24 clks after start sample.
- Same config, run dropped during 2nd pulse → fire=0 next clk, state IDLE, count_done=1, done=0. Re-asserting run restarts with count_done cleared to 0.
- clk_div=0, period=4, width=7, count=2 → width clamped to 3 ticks: fire high 6 clks, low 2 clks, twice; done=1.
- period=0 (or count=0), run=1 → done=1 one clk later, count_done=0, fire never asserts, busy never asserts.
- Mid-run: change period 4→8 and count 3→5 → ignored, run finishes with the old values. After run=0 then run=1, the new values take effect and done clears on the start edge.
- rst pulsed asynchronously (between clk edges) while fire=1 → fire, count_done, done, busy all 0 before the next clk edge. fire stays 0 after rst release until run=1 is sampled in IDLE.
